// File: rtl/spi_target_phy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_phy_pkg
// Brief    : Shared FSM encodings and pin-synchronizer channel map for the
//            SPI target PHY.
// Revision : 1.0 - initial release
// ============================================================================
package spi_target_phy_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_ARM   = 2'd1;
    localparam state_t c_ST_SHIFT = 2'd2;

    // Channel map: edge-detected pins occupy the low indices, data-only above.
    localparam int c_SYNC_CH   = 3;
    localparam int c_EDGE_CH   = 2;
    localparam int c_CH_CS     = 0;
    localparam int c_CH_SCLK   = 1;

endpackage
`default_nettype wire

// File: rtl/spi_target_phy_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_phy_pin_sync
// Brief    : 2-FF synchronizer for asynchronous SPI pins; the low N_EDGE
//            channels also get a third flop and rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module spi_target_phy_pin_sync
    import spi_target_phy_pkg::*;
#(
    parameter int N_CH   = c_SYNC_CH,
    parameter int N_EDGE = c_EDGE_CH
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_CH-1:0]        i_pin,
    output logic [N_CH-N_EDGE-1:0] o_data,
    output logic [N_EDGE-1:0]      o_rise,
    output logic [N_EDGE-1:0]      o_fall
);

    logic [N_CH-1:0]   r_meta;
    logic [N_CH-1:0]   r_sync;
    logic [N_EDGE-1:0] r_dly;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_dly  <= '0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_dly  <= r_sync[N_EDGE-1:0];
        end
    end

    assign o_data = r_sync[N_CH-1:N_EDGE];
    assign o_rise = r_sync[N_EDGE-1:0] & ~r_dly;
    assign o_fall = ~r_sync[N_EDGE-1:0] & r_dly;

endmodule
`default_nettype wire

// File: rtl/spi_target_phy.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_phy
// Brief    : SPI mode-0 target PHY, MSB first, oversampled in i_clk domain,
//            with rdy/rd receive and bsy/wr transmit handshakes.
//            Optional sticky overrun flag o_ovr: define SPI_TARGET_OVERRUN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_target_phy
    import spi_target_phy_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] FILL  = WIDTH'(8'hFF)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             s_cs,
    input  logic             s_clk,
    input  logic             s_copi,
    output logic             s_cipo,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_rdy,
    input  logic             i_rd,
    output logic             o_bsy,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata
`ifdef SPI_TARGET_OVERRUN_EN
    ,
    output logic             o_ovr
`endif
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    logic [0:0]         w_data;
    logic [1:0]         w_rise;
    logic [1:0]         w_fall;
    logic               w_cs_rise, w_cs_fall, w_sclk_rise, w_sclk_fall;

    state_t             r_state, w_state_nxt;
    logic               r_armed;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_tx;
    logic [WIDTH-2:0]   r_rx;
    logic [WIDTH-1:0]   r_hold;
    logic               r_bsy;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_rdy;

    logic               w_load, w_shift, w_sample, w_done;
    logic [WIDTH-1:0]   w_tx_src;
    logic [WIDTH-1:0]   w_rx_word;

    spi_target_phy_pin_sync #(
        .N_CH   (c_SYNC_CH),
        .N_EDGE (c_EDGE_CH)
    ) u_pin_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_pin   ({s_copi, s_clk, s_cs}),
        .o_data  (w_data),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_cs_rise   = w_rise[c_CH_CS];
    assign w_cs_fall   = w_fall[c_CH_CS];
    assign w_sclk_rise = w_rise[c_CH_SCLK];
    assign w_sclk_fall = w_fall[c_CH_SCLK];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_rise) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:  if (w_cs_fall && r_armed) w_state_nxt = c_ST_ARM;
                c_ST_ARM:   w_state_nxt = c_ST_SHIFT;
                c_ST_SHIFT: w_state_nxt = c_ST_SHIFT;
                default:    w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // A fall with the bit count at zero follows a completed word: reload tx.
    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_sample = 1'b0;
        if (!w_cs_rise) begin
            case (r_state)
                c_ST_ARM: w_load = 1'b1;
                c_ST_SHIFT: begin
                    w_load   = w_sclk_fall && (r_cnt == '0);
                    w_shift  = w_sclk_fall && (r_cnt != '0);
                    w_sample = w_sclk_rise;
                end
                default: ;
            endcase
        end
        w_done = w_sample && (r_cnt == c_LAST);
    end

    assign w_tx_src  = r_bsy ? r_hold : FILL;
    assign w_rx_word = {r_rx, w_data[0]};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_hold  <= '0;
            r_bsy   <= 1'b0;
            r_rdata <= '0;
            r_rdy   <= 1'b0;
        end else begin
            if (w_cs_rise) begin
                r_armed <= 1'b1;
            end

            if (w_cs_rise) begin
                r_tx <= '0;
            end else if (w_load) begin
                r_tx <= w_tx_src;
            end else if (w_shift) begin
                r_tx <= {r_tx[WIDTH-2:0], 1'b0};
            end

            if (r_state == c_ST_ARM) begin
                r_cnt <= '0;
            end else if (w_sample) begin
                r_cnt <= w_done ? '0 : r_cnt + 1'b1;
                r_rx  <= w_rx_word[WIDTH-2:0];
            end

            if (i_wr && !r_bsy) begin
                r_hold <= i_wdata;
                r_bsy  <= 1'b1;
            end else if (w_load && r_bsy) begin
                r_bsy  <= 1'b0;
            end

            if (w_done) begin
                r_rdata <= w_rx_word;
                r_rdy   <= 1'b1;
            end else if (i_rd) begin
                r_rdy   <= 1'b0;
            end
        end
    end

`ifdef SPI_TARGET_OVERRUN_EN
    logic r_ovr;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ovr <= 1'b0;
        end else if (w_done && r_rdy && !i_rd) begin
            r_ovr <= 1'b1;
        end else if (i_rd && r_rdy) begin
            r_ovr <= 1'b0;
        end
    end

    assign o_ovr = r_ovr;
`else
    // Without the flag a late reader simply sees the newest word.
`endif

    assign s_cipo  = r_tx[WIDTH-1];
    assign o_rdata = r_rdata;
    assign o_rdy   = r_rdy;
    assign o_bsy   = r_bsy;

endmodule
`default_nettype wire
